// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the two-master RAM arbiter.
// RAM_ARB_FIXED_PRIO_EN selects fixed priority in ram_arb_pick; it is not used in this file.
package ram_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

endpackage

// File: rtl/ram_arb_if.sv
// Requester-side bus for one master of the RAM arbiter.
// RAM_ARB_FIXED_PRIO_EN selects fixed priority in ram_arb_pick; it is not used in this file.
interface ram_arb_if #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
);
    logic          req;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          ack;
    logic [DW-1:0] rdata;

    modport master (
        output req, we, addr, wdata,
        input  ack, rdata
    );

    modport slave (
        input  req, we, addr, wdata,
        output ack, rdata
    );
endinterface

// File: rtl/ram_arb_pick.sv
// Combinational winner selection for two requesters.
// Round-robin by default; RAM_ARB_FIXED_PRIO_EN gives m0 fixed priority.
module ram_arb_pick
    import ram_arb_pkg::*;
(
    input  logic req0_i,
    input  logic req1_i,
    input  logic last_grant_i,
    output logic gnt_o,
    output logic valid_o
);

    always_comb begin
        valid_o = req0_i | req1_i;
        gnt_o   = M0;
        if (req0_i && req1_i) begin
`ifdef RAM_ARB_FIXED_PRIO_EN
            gnt_o = M0;
`else
            gnt_o = ~last_grant_i;
`endif
        end else if (req1_i) begin
            gnt_o = M1;
        end
    end

`ifdef RAM_ARB_FIXED_PRIO_EN
    logic unused_last_grant;
    assign unused_last_grant = last_grant_i;
`endif

endmodule

// File: rtl/ram_arbiter.sv
// Two-master arbiter for a single-port tristate RAM: one bus cycle per access, one-cycle ack.
// RAM_ARB_FIXED_PRIO_EN (handled in ram_arb_pick) switches round-robin to fixed m0 priority.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    ram_arb_if.slave      m0,
    ram_arb_if.slave      m1,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    inout  wire  [DW-1:0] mem_data
);

    state_e        state_q;
    logic          win_q;
    logic          we_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic          last_grant_q;
    logic          ack0_q, ack1_q;
    logic [DW-1:0] rdata0_q, rdata1_q;

    logic          gnt;
    logic          gnt_valid;

    ram_arb_pick u_pick (
        .req0_i       (m0.req),
        .req1_i       (m1.req),
        .last_grant_i (last_grant_q),
        .gnt_o        (gnt),
        .valid_o      (gnt_valid)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            win_q        <= M0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            last_grant_q <= M1;
            ack0_q       <= 1'b0;
            ack1_q       <= 1'b0;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (gnt_valid) begin
                        state_q      <= ST_BUSY;
                        win_q        <= gnt;
                        last_grant_q <= gnt;
                        we_q         <= (gnt == M0) ? m0.we    : m1.we;
                        addr_q       <= (gnt == M0) ? m0.addr  : m1.addr;
                        wdata_q      <= (gnt == M0) ? m0.wdata : m1.wdata;
                    end
                end
                ST_BUSY: begin
                    state_q <= ST_RESP;
                    ack0_q  <= (win_q == M0);
                    ack1_q  <= (win_q == M1);
                    // The RAM drives mem_data during a read BUSY cycle.
                    if (!we_q) begin
                        if (win_q == M0) rdata0_q <= mem_data;
                        else             rdata1_q <= mem_data;
                    end
                end
                ST_RESP: begin
                    state_q <= ST_IDLE;
                    ack0_q  <= 1'b0;
                    ack1_q  <= 1'b0;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // rst gates the write so a reset edge never commits an in-flight write.
    assign mem_we   = (state_q == ST_BUSY) && we_q && !rst;
    assign mem_addr = (state_q == ST_BUSY) ? addr_q : '0;
    assign mem_data = ((state_q == ST_BUSY) && we_q) ? wdata_q : {DW{1'bz}};

    assign m0.ack   = ack0_q;
    assign m1.ack   = ack1_q;
    assign m0.rdata = rdata0_q;
    assign m1.rdata = rdata1_q;

endmodule
